// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
// mux_stream_rr : N-channel registered stream mux, fixed-select or round-robin,
//                 grant locked to one channel until a packet's last beat.
// Rev 1.0
// ============================================================================
module mux_stream_rr #(
  parameter int N      = 4,
  parameter int WIDTH  = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  input  logic                 rr_mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             grant_vld;
  logic [SELW-1:0]  grant_ch;
  logic [SELW-1:0]  scan_idx;
  logic             can_load;
  logic             xfer;

  // Round-robin scan starts one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    scan_idx  = '0;
    if (state_q == ST_LOCKED) begin
      grant_vld = 1'b1;
      grant_ch  = lock_ch_q;
    end else if (!rr_mode) begin
      grant_vld = (int'(sel) < N);
      grant_ch  = sel;
    end else begin
      for (int i = 1; i <= N; i++) begin
        scan_idx = SELW'((int'(ptr_q) + i) % N);
        if (!grant_vld && in_valid[scan_idx]) begin
          grant_vld = 1'b1;
          grant_ch  = scan_idx;
        end
      end
    end
  end

  assign can_load = !out_valid_q || out_ready;
  assign xfer     = grant_vld && can_load && rst_n && in_valid[grant_ch];

  always_comb begin
    in_ready = '0;
    if (grant_vld && can_load && rst_n) in_ready[grant_ch] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = in_data[int'(grant_ch)*WIDTH +: WIDTH];
      out_last_d  = in_last[grant_ch];
      out_ch_d    = grant_ch;
      out_valid_d = 1'b1;
      ptr_d       = grant_ch;
      if (state_q == ST_IDLE && !in_last[grant_ch]) begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant_ch;
      end else if (state_q == ST_LOCKED && in_last[grant_ch]) begin
        state_d   = ST_IDLE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      ptr_q       <= SELW'(N - 1);
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_rr.sv
`default_nettype none
// Directed self-checking bench for mux_stream_rr (N=4, WIDTH=8).
module tb_mux_stream_rr;

  logic        clk;
  logic        rst_n;
  logic [7:0]  d [4];
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        rr_mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int tests;
  int fails;

  assign in_data = {d[3], d[2], d[1], d[0]};

  mux_stream_rr #(.N(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .rr_mode   (rr_mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rr_mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; in_last = 4'b1111;
    d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;
    step(); step();
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b exp 0000", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h exp 00", out_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: got %b exp 0001", in_ready); end
    step();
    tests++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin fails++; $display("FAIL reset_first_out: got ch=%0d v=%b exp ch=0 v=1", out_ch, out_valid); end
  endtask

  task automatic test_fixed_select();
    rr_mode = 1'b0; sel = 2'd2; d[2] = 8'hA5; in_last = 4'b1111; in_valid = 4'b1111;
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL fixed_in_ready: got %b exp 0100", in_ready); end
    step();
    tests++; if (out_data !== 8'hA5 || out_ch !== 2'd2 || out_last !== 1'b1) begin
      fails++; $display("FAIL fixed_out: got d=%h ch=%0d l=%b exp d=a5 ch=2 l=1", out_data, out_ch, out_last); end
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL fixed_sel3_ready: got %b exp 1000", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      fails++; $display("FAIL fixed_no_xfer: got v=%b d=%h exp v=0 d=a5", out_valid, out_data); end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_ch [6];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rr_mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (out_ch !== exp_ch[i] || out_valid !== 1'b1) begin
        fails++; $display("FAIL rr_beat%0d: got ch=%0d v=%b exp ch=%0d v=1", i, out_ch, out_valid, exp_ch[i]); end
    end
  endtask

  task automatic test_packet_lock();
    in_valid = 4'b0001; in_last = 4'b1111; d[0] = 8'h00;
    step();
    d[1] = 8'h11; d[2] = 8'h22; in_valid = 4'b0111; in_last = 4'b1101;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL lock_first_ready: got %b exp 0010", in_ready); end
    step();
    tests++; if (out_ch !== 2'd1 || out_data !== 8'h11 || busy !== 1'b1) begin
      fails++; $display("FAIL lock_beat1: got ch=%0d d=%h busy=%b exp ch=1 d=11 busy=1", out_ch, out_data, busy); end
    rr_mode = 1'b0; sel = 2'd0; d[1] = 8'h12;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL lock_hold_ready: got %b exp 0010", in_ready); end
    step();
    tests++; if (out_ch !== 2'd1 || out_data !== 8'h12 || busy !== 1'b1) begin
      fails++; $display("FAIL lock_beat2: got ch=%0d d=%h busy=%b exp ch=1 d=12 busy=1", out_ch, out_data, busy); end
    rr_mode = 1'b1; sel = 2'd2; d[1] = 8'h13; in_last = 4'b1111;
    step();
    tests++; if (out_ch !== 2'd1 || out_data !== 8'h13 || out_last !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL lock_beat3: got ch=%0d d=%h l=%b busy=%b exp ch=1 d=13 l=1 busy=0", out_ch, out_data, out_last, busy); end
    in_valid = 4'b0101;
    step();
    tests++; if (out_ch !== 2'd2 || out_data !== 8'h22 || out_valid !== 1'b1) begin
      fails++; $display("FAIL lock_next_grant: got ch=%0d d=%h v=%b exp ch=2 d=22 v=1", out_ch, out_data, out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0001; in_last = 4'b1111; d[0] = 8'h3C;
    step();
    tests++; if (out_data !== 8'h3C || out_ch !== 2'd0) begin
      fails++; $display("FAIL bp_load: got d=%h ch=%0d exp d=3c ch=0", out_data, out_ch); end
    out_ready = 1'b0; d[0] = 8'h4D;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready%0d: got %b exp 0000", i, in_ready); end
      step();
      tests++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold%0d: got d=%h v=%b exp d=3c v=1", i, out_data, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL bp_release_ready: got %b exp 0001", in_ready); end
    step();
    tests++; if (out_data !== 8'h4D || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_drain_load: got d=%h v=%b exp d=4d v=1", out_data, out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    in_valid = 4'b0100; in_last = 4'b0000; d[2] = 8'h21;
    step();
    tests++; if (out_ch !== 2'd2 || busy !== 1'b1) begin
      fails++; $display("FAIL rmid_beat1: got ch=%0d busy=%b exp ch=2 busy=1", out_ch, busy); end
    d[2] = 8'h22; rst_n = 1'b0;
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL rmid_ready: got %b exp 0000", in_ready); end
    step();
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rmid_after_reset: got busy=%b v=%b exp busy=0 v=0", busy, out_valid); end
    rst_n = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL rmid_grant: got %b exp 0001", in_ready); end
    step();
    tests++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL rmid_out: got ch=%0d v=%b exp ch=0 v=1", out_ch, out_valid); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; rr_mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
    in_valid = 4'b0000; in_last = 4'b0000;
    d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
    test_reset();
    test_fixed_select();
    test_rr_fairness();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
